// File: rtl/wall_follower_ctrl.sv
// Left-hand wall-following motion controller for the pipe-cleaning robot.
// Optional build macro MOVE_COUNTER_EN adds the saturating forward-move counter port `moves`.
module wall_follower_ctrl #(
    parameter int REMOVE_CYCLES = 3,
    parameter int ROTATE_TURNS  = 3,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic head,
    input  logic left,
    input  logic under,
    input  logic barrier,
    output logic front,
    output logic turn,
    output logic remove,
    output logic halted
`ifdef MOVE_COUNTER_EN
    ,
    output logic [COUNT_WIDTH-1:0] moves
`endif
);

    localparam int RW = $clog2(ROTATE_TURNS + 1);
    localparam int CW = $clog2(REMOVE_CYCLES + 1);
    localparam logic [RW-1:0] ROT_LOAD  = RW'(ROTATE_TURNS - 1);
    localparam logic [CW-1:0] REM_FIRST = CW'(1);
    localparam logic [CW-1:0] REM_LAST  = CW'(REMOVE_CYCLES);

    typedef enum logic [2:0] {
        IDLE, SEARCH, FOLLOW, ROTATE, FWD_AFTER_TURN, REMOVE, HALT
    } state_t;

    state_t        state, ret;
    logic [RW-1:0] rot_cnt;
    logic [CW-1:0] rem_cnt;
    logic          fwd_next;

    // Forward decision is shared by the FSM and the optional move counter.
    always_comb begin
        fwd_next = 1'b0;
        if (!under && !barrier) begin
            case (state)
                SEARCH:         fwd_next = !head;
                FOLLOW:         fwd_next = left && !head;
                FWD_AFTER_TURN: fwd_next = 1'b1;
                default:        fwd_next = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            ret     <= SEARCH;
            front   <= 1'b0;
            turn    <= 1'b0;
            remove  <= 1'b0;
            halted  <= 1'b0;
            rot_cnt <= '0;
            rem_cnt <= '0;
        end else begin
            front  <= fwd_next;
            turn   <= 1'b0;
            remove <= 1'b0;
            case (state)
                IDLE: state <= SEARCH;
                SEARCH: begin
                    if (under) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else if (barrier) begin
                        state   <= REMOVE;
                        ret     <= SEARCH;
                        remove  <= 1'b1;
                        rem_cnt <= REM_FIRST;
                    end else if (head) begin
                        turn <= 1'b1;
                        ret  <= FOLLOW;
                        if (ROTATE_TURNS > 1) begin
                            state   <= ROTATE;
                            rot_cnt <= ROT_LOAD;
                        end else begin
                            state <= FOLLOW;
                        end
                    end else if (left) begin
                        state <= FOLLOW;
                    end
                end
                FOLLOW: begin
                    if (under) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else if (barrier) begin
                        state   <= REMOVE;
                        ret     <= FOLLOW;
                        remove  <= 1'b1;
                        rem_cnt <= REM_FIRST;
                    end else if (!left) begin
                        turn  <= 1'b1;
                        state <= FWD_AFTER_TURN;
                    end else if (head) begin
                        turn <= 1'b1;
                        ret  <= FOLLOW;
                        if (ROTATE_TURNS > 1) begin
                            state   <= ROTATE;
                            rot_cnt <= ROT_LOAD;
                        end
                    end
                end
                // rot_cnt holds the turns still owed; the one issued now is the last at 1.
                ROTATE: begin
                    if (under) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else begin
                        turn <= 1'b1;
                        if (rot_cnt <= RW'(1)) begin
                            rot_cnt <= '0;
                            state   <= ret;
                        end else begin
                            rot_cnt <= rot_cnt - RW'(1);
                        end
                    end
                end
                FWD_AFTER_TURN: begin
                    if (under) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else if (barrier) begin
                        state   <= REMOVE;
                        ret     <= FOLLOW;
                        remove  <= 1'b1;
                        rem_cnt <= REM_FIRST;
                    end else begin
                        state <= FOLLOW;
                    end
                end
                // The cycle after the last remove pulse is a silent re-evaluation slot.
                REMOVE: begin
                    if (rem_cnt == REM_LAST) begin
                        rem_cnt <= '0;
                        state   <= ret;
                    end else begin
                        remove  <= 1'b1;
                        rem_cnt <= rem_cnt + CW'(1);
                    end
                end
                HALT:    halted <= 1'b1;
                default: state  <= IDLE;
            endcase
        end
    end

`ifdef MOVE_COUNTER_EN
    always_ff @(posedge clock) begin
        if (reset)
            moves <= '0;
        else if (fwd_next && moves != '1)
            moves <= moves + COUNT_WIDTH'(1);
    end
`endif

endmodule

// File: tb/tb_wall_follower_ctrl.sv
// Bench for wall_follower_ctrl: directed walk plus randomized sensors vs. a command-queue reference model.
module tb_wall_follower_ctrl;

    localparam int REMOVE_CYCLES = 3;
    localparam int ROTATE_TURNS  = 3;
    localparam int COUNT_WIDTH   = 16;

    localparam int M_IDLE = 0, M_SEARCH = 1, M_FOLLOW = 2, M_FWD = 3, M_HALT = 4;
    localparam int C_NONE = 0, C_TURN = 1, C_REM = 2;

    logic clock = 1'b0;
    logic reset, head, left, under, barrier;
    logic front, turn, remove, halted;
`ifdef MOVE_COUNTER_EN
    logic [COUNT_WIDTH-1:0] moves;
    logic [COUNT_WIDTH-1:0] e_moves;
`endif

    int tests  = 0;
    int failed = 0;
    int cycle  = 0;

    // Reference model: a walk mode plus a queue of already-committed commands.
    int   mode;
    int   q[$];
    logic ef, et, er, eh;

    always #5 clock = ~clock;

    wall_follower_ctrl #(
        .REMOVE_CYCLES(REMOVE_CYCLES),
        .ROTATE_TURNS (ROTATE_TURNS),
        .COUNT_WIDTH  (COUNT_WIDTH)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .head   (head),
        .left   (left),
        .under  (under),
        .barrier(barrier),
        .front  (front),
        .turn   (turn),
        .remove (remove),
        .halted (halted)
`ifdef MOVE_COUNTER_EN
        ,
        .moves  (moves)
`endif
    );

    task automatic go_halt();
        mode = M_HALT;
        q.delete();
        eh = 1'b1;
    endtask

    task automatic go_remove();
        er = 1'b1;
        for (int i = 1; i < REMOVE_CYCLES; i++) q.push_back(C_REM);
        q.push_back(C_NONE);
    endtask

    task automatic go_rotate();
        et = 1'b1;
        for (int i = 1; i < ROTATE_TURNS; i++) q.push_back(C_TURN);
        mode = M_FOLLOW;
    endtask

    task automatic model_step();
        int c;
        ef = 1'b0; et = 1'b0; er = 1'b0;
        if (reset) begin
            mode = M_IDLE;
            q.delete();
            eh = 1'b0;
`ifdef MOVE_COUNTER_EN
            e_moves = '0;
`endif
            return;
        end
        if (mode == M_HALT) begin
            eh = 1'b1;
        end else if (q.size() > 0) begin
            if (q[0] == C_TURN && under) go_halt();
            else begin
                c  = q.pop_front();
                et = (c == C_TURN);
                er = (c == C_REM);
            end
        end else begin
            case (mode)
                M_IDLE: mode = M_SEARCH;
                M_SEARCH: begin
                    if (under)        go_halt();
                    else if (barrier) go_remove();
                    else if (head)    go_rotate();
                    else begin
                        ef = 1'b1;
                        if (left) mode = M_FOLLOW;
                    end
                end
                M_FOLLOW: begin
                    if (under)        go_halt();
                    else if (barrier) go_remove();
                    else if (!left) begin
                        et   = 1'b1;
                        mode = M_FWD;
                    end
                    else if (head)    go_rotate();
                    else              ef = 1'b1;
                end
                default: begin
                    if (under) go_halt();
                    else begin
                        if (barrier) go_remove();
                        else         ef = 1'b1;
                        mode = M_FOLLOW;
                    end
                end
            endcase
        end
`ifdef MOVE_COUNTER_EN
        if (ef && e_moves != '1) e_moves = e_moves + 1'b1;
`endif
    endtask

    task automatic check();
        tests++;
        assert ({front, turn, remove, halted} === {ef, et, er, eh})
        else begin
            failed++;
            $error("FAIL cmd cyc=%0d got f/t/r/h=%b%b%b%b exp %b%b%b%b",
                   cycle, front, turn, remove, halted, ef, et, er, eh);
        end
        tests++;
        assert (front + turn + remove <= 1)
        else begin
            failed++;
            $error("FAIL onehot cyc=%0d got f/t/r=%b%b%b exp at most one set",
                   cycle, front, turn, remove);
        end
`ifdef MOVE_COUNTER_EN
        tests++;
        assert (moves === e_moves)
        else begin
            failed++;
            $error("FAIL moves cyc=%0d got %0d exp %0d", cycle, moves, e_moves);
        end
`endif
    endtask

    // Inputs change at negedge, model and DUT advance on posedge, outputs checked at next negedge.
    task automatic cyc(input logic h, input logic l, input logic u, input logic b);
        head = h; left = l; under = u; barrier = b;
        @(posedge clock);
        model_step();
        cycle++;
        @(negedge clock);
        check();
    endtask

    initial begin
        mode = M_IDLE; ef = 0; et = 0; er = 0; eh = 0;
`ifdef MOVE_COUNTER_EN
        e_moves = '0;
`endif
        reset = 1'b1; head = 0; left = 0; under = 0; barrier = 0;
        @(negedge clock);

        // Reset, idle cycle, then forward search
        cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
        reset = 1'b0;
        cyc(0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0);

        // Head in search: right turn as three left turns, then follow
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
        repeat (3) cyc(0, 1, 0, 0);

        // Lost the left wall: turn, then forced forward even with head set
        cyc(0, 0, 0, 0);
        cyc(1, 1, 0, 0);
        repeat (2) cyc(0, 1, 0, 0);

        // Trash ahead: three removes, one silent cycle, then forward
        cyc(0, 1, 0, 1);
        repeat (5) cyc(0, 1, 0, 0);

        // Terminal cell during rotation halts immediately
        cyc(1, 1, 0, 0);
        cyc(0, 1, 1, 0);
        repeat (10) cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        reset = 1'b1; cyc(0, 0, 0, 0);
        reset = 1'b0;

        // Edge case: under and barrier together
        cyc(0, 0, 0, 0); cyc(0, 0, 1, 1); cyc(0, 0, 0, 0);
        reset = 1'b1; cyc(0, 0, 0, 0);
        reset = 1'b0;

        // Randomized walk with occasional resets, including mid-rotation/removal
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0) || (halted && $urandom_range(0, 7) == 0);
            cyc($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 60,
                $urandom_range(0, 99) < 2,  $urandom_range(0, 99) < 8);
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
